lbist_seq_ctrl: RTL and testbench
=================================

Name: lbist_seq_ctrl

Overview:
Sequencer for one LBIST run. It owns the pattern-generator counter's increment input, clears the generator and MISR, and steps the generator through a programmed number of patterns. It then drains the response pipeline into the MISR and compares the final signature against a golden value. It sits between the test-access/config logic and the pattern counter + MISR datapath.

Parameters:
BITS, 8, width of pattern counter and pattern-count fields (matches generator count width)
SIG_W, 16, MISR signature width
SETTLE, 2, drain cycles after last pattern before compare (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  terminate the current run
num_patterns  in  BITS  patterns to apply; 0 = full sweep of 2^BITS
golden_sig  in  SIG_W  expected signature; sampled in COMPARE
misr_sig  in  SIG_W  current MISR contents
gen_inc  out  1  increment to the pattern counter
gen_clear  out  1  synchronous clear to the pattern counter
misr_clear  out  1  synchronous clear to the MISR
misr_en  out  1  MISR compaction enable
test_mode  out  1  selects the BIST path in the CUT muxes
busy  out  1  high in every state except IDLE
done  out  1  run finished; sticky until next accepted start
pass  out  1  signature matched; valid while done=1
patterns_run  out  BITS  gen_inc pulses issued in the current or last run (mod 2^BITS)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; all outputs 0; patterns_run=0; internal counters 0.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: start=1 and abort=0 moves to SETUP. In the same edge, done and pass clear and num_patterns is latched into N. A start while busy=1 is ignored.
  - SETUP (1 cycle): gen_clear=1, misr_clear=1, test_mode=1. patterns_run clears to 0. Always moves to RUN.
  - RUN: gen_inc=1, misr_en=1, test_mode=1 every cycle. patterns_run increments each cycle. After exactly N cycles (2^BITS cycles if N=0), moves to DRAIN.
  - DRAIN: misr_en=1, gen_inc=0, test_mode=1 for exactly SETTLE cycles, then moves to COMPARE.
  - COMPARE (1 cycle): test_mode=1, misr_en=0. Registers pass <= (misr_sig == golden_sig) and done <= 1, then moves to IDLE.
- Latency: start sampled at edge 0; done and pass are visible after edge N+SETTLE+2, i.e. N+SETTLE+3 cycles after start is driven.
- Abort: in any non-IDLE state, abort=1 returns to IDLE on the next edge with done=1, pass=0, and all strobes 0. patterns_run holds its partial count. In IDLE, abort is ignored. If start and abort are both high in IDLE, abort wins: no run starts and done/pass are unchanged.
- Full sweep: with N=0, gen_inc is high for 2^BITS cycles. The generator wraps back to its start value, and patterns_run reads 0 at completion.
- N latch: num_patterns and golden_sig changes during a run have no effect on length. golden_sig is only used in COMPARE.
- Reset mid-run: rst_n low immediately forces IDLE and all outputs 0, regardless of clk.
- Back-to-back runs: a start in the cycle after COMPARE (now IDLE, done=1) is accepted and clears done.

Test Plan:
- Reset: hold rst_n=0 mid-RUN with no clk edge -> all outputs 0 at once; after release, busy=0 and done=0.
- Basic run, N=4, SETTLE=2, golden_sig=misr_sig=16'hBEEF: gen_inc high for exactly 4 cycles; misr_en high for 6; done=1 and pass=1 appear 9 cycles after start; patterns_run=4.
- Mismatch: N=3, misr_sig=16'h1234, golden_sig=16'h1235 -> done=1, pass=0, patterns_run=3.
- Full sweep, BITS=8, num_patterns=0: exactly 256 gen_inc cycles; patterns_run=0 at done; attached counter returns to its start value.
- Abort: abort=1 on the 3rd RUN cycle with N=10 -> next cycle IDLE, done=1, pass=0, patterns_run=3. Start and abort high together in IDLE -> busy stays 0.
- Re-trigger: start pulsed during RUN is ignored (run length unchanged). A new start right after done clears done; a 2nd run with N=1 completes in 1+SETTLE+3 cycles.

Source files
------------

// File: rtl/lbist_seq_ctrl.sv
// Purpose : sequences one LBIST run (clear, pattern stepping, drain, signature compare).
// Latency : start sampled at edge 0; done/pass valid after edge N+SETTLE+2.
// Backpr. : none; start is only honoured in IDLE, and abort ends any active run on the next edge.
//
// Ports:
//   clk, rst_n    - system clock (rising edge), asynchronous active-low reset
//   start, abort  - run request (IDLE only) and run termination (non-IDLE only)
//   num_patterns  - patterns to apply, latched at start; 0 selects a full 2^BITS sweep
//   golden_sig    - expected signature, sampled in COMPARE
//   misr_sig      - live MISR contents
//   gen_inc/gen_clear, misr_clear/misr_en, test_mode - datapath strobes
//   busy, done, pass, patterns_run - run status

`default_nettype none

module lbist_seq_ctrl #(
    parameter int BITS   = 8,
    parameter int SIG_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [BITS-1:0]  num_patterns,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             gen_inc,
    output logic             gen_clear,
    output logic             misr_clear,
    output logic             misr_en,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [BITS-1:0]  patterns_run
);

    // Drain counter only needs to hold 0..SETTLE-1.
    localparam int DW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_COMPARE = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BITS-1:0] n_lat;
    logic [DW-1:0]   drain_cnt;
    logic            run_last;
    logic            drain_last;

    // patterns_run counts RUN cycles from 0; leaving when it equals N-1 gives
    // exactly N cycles. N=0 wraps N-1 to all-ones, which yields the full sweep.
    assign run_last   = (patterns_run == (n_lat - BITS'(1)));
    assign drain_last = (drain_cnt == DRAIN_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (run_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every transition out of an active state.
        if ((state != S_IDLE) && abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Strobes are registered from the next state so each one is high exactly
    // while the FSM sits in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            n_lat        <= '0;
            drain_cnt    <= '0;
            patterns_run <= '0;
            gen_inc      <= 1'b0;
            gen_clear    <= 1'b0;
            misr_clear   <= 1'b0;
            misr_en      <= 1'b0;
            test_mode    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state      <= state_nxt;
            gen_inc    <= (state_nxt == S_RUN);
            gen_clear  <= (state_nxt == S_SETUP);
            misr_clear <= (state_nxt == S_SETUP);
            misr_en    <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            test_mode  <= (state_nxt != S_IDLE);
            busy       <= (state_nxt != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        n_lat <= num_patterns;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    patterns_run <= '0;
                    drain_cnt    <= '0;
                end
                S_RUN: begin
                    // Counts this cycle's gen_inc pulse even if the run is aborted now.
                    patterns_run <= patterns_run + BITS'(1);
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                S_COMPARE: begin
                    pass <= (misr_sig == golden_sig);
                    done <= 1'b1;
                end
                default: begin
                end
            endcase

            // An aborted run reports finished-but-failed; placed last so it
            // also wins over a compare happening in the same cycle.
            if ((state != S_IDLE) && abort) begin
                done <= 1'b1;
                pass <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lbist_seq_ctrl.sv
// Purpose : self-checking bench for lbist_seq_ctrl (BITS=8, SIG_W=16, SETTLE=2).
// Latency : stimulus pushes expected run results; a negedge monitor checks them at done.
// Backpr. : n/a.

`timescale 1ns/1ps

module tb_lbist_seq_ctrl;

    localparam int BITS   = 8;
    localparam int SIG_W  = 16;
    localparam int SETTLE = 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [BITS-1:0]  num_patterns;
    logic [SIG_W-1:0] golden_sig;
    logic [SIG_W-1:0] misr_sig;
    logic             gen_inc;
    logic             gen_clear;
    logic             misr_clear;
    logic             misr_en;
    logic             test_mode;
    logic             busy;
    logic             done;
    logic             pass;
    logic [BITS-1:0]  patterns_run;

    lbist_seq_ctrl #(
        .BITS  (BITS),
        .SIG_W (SIG_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_patterns(num_patterns),
        .golden_sig  (golden_sig),
        .misr_sig    (misr_sig),
        .gen_inc     (gen_inc),
        .gen_clear   (gen_clear),
        .misr_clear  (misr_clear),
        .misr_en     (misr_en),
        .test_mode   (test_mode),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .patterns_run(patterns_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached pattern counter driven by the sequencer strobes.
    logic [BITS-1:0] ctr;
    always @(posedge clk) begin
        if (gen_clear)    ctr <= '0;
        else if (gen_inc) ctr <= ctr + 1'b1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic pass;
        int   prun;
        int   incs;
        int   ens;
        int   lat;
        int   ctr;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input logic p, input int pr, input int i, input int e,
                        input int l, input int c);
        exp_t x;
        x.pass = p; x.prun = pr; x.incs = i; x.ens = e; x.lat = l; x.ctr = c;
        exp_q.push_back(x);
    endtask

    // Monitor: counts strobe cycles over each busy window, checks on done rising.
    initial begin
        int   bcyc;
        int   incs;
        int   ens;
        logic busy_q;
        logic done_q;
        exp_t x;
        bcyc = 0; incs = 0; ens = 0; busy_q = 1'b0; done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !busy_q) begin
                bcyc = 1;
                incs = int'(gen_inc);
                ens  = int'(misr_en);
            end else if (busy) begin
                bcyc++;
                incs += int'(gen_inc);
                ens  += int'(misr_en);
            end
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    chk("pass",         32'(pass),         32'(x.pass));
                    chk("patterns_run", 32'(patterns_run), x.prun);
                    chk("gen_inc_cnt",  incs,              x.incs);
                    chk("misr_en_cnt",  ens,               x.ens);
                    chk("latency",      bcyc + 1,          x.lat);
                    chk("counter",      32'(ctr),          x.ctr);
                end
            end
            busy_q = busy;
            done_q = done;
        end
    end

    // Called at posedge+1: start is sampled at the next edge, then released.
    task automatic kick(input logic [BITS-1:0] n, input logic [SIG_W-1:0] g,
                        input logic [SIG_W-1:0] s);
        num_patterns = n;
        golden_sig   = g;
        misr_sig     = s;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt > 1000) begin
                chk("timeout", 32'(busy), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        num_patterns = '0;
        golden_sig   = '0;
        misr_sig     = '0;

        #12;
        chk("reset_strobes", {gen_inc, gen_clear, misr_clear, misr_en, test_mode, busy, done, pass}, 32'd0);
        chk("reset_prun", 32'(patterns_run), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_done", 32'(done), 32'd0);

        // Basic run: N=4, matching signature.
        push(1'b1, 4, 4, 6, 9, 4);
        kick(8'd4, 16'hBEEF, 16'hBEEF);
        wait_idle();

        // Signature mismatch: N=3.
        push(1'b0, 3, 3, 5, 8, 3);
        kick(8'd3, 16'h1235, 16'h1234);
        wait_idle();

        // start and abort together in IDLE: nothing starts, done/pass kept.
        start = 1'b1;
        abort = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_done", 32'(done), 32'd1);
        chk("idle_abort_pass", 32'(pass), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;

        // Abort on the 3rd RUN cycle of an N=10 run.
        push(1'b0, 3, 3, 3, 5, 3);
        kick(8'd10, 16'h5555, 16'h5555);     // now in SETUP
        @(posedge clk); #1;                  // RUN cycle 1
        @(posedge clk); #1;                  // RUN cycle 2
        @(posedge clk); #1;                  // RUN cycle 3
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_strobes", {gen_inc, gen_clear, misr_clear, misr_en, test_mode}, 32'd0);
        @(posedge clk); #1;

        // Start pulsed during RUN and num_patterns changed: length stays 5.
        push(1'b1, 5, 5, 7, 10, 5);
        kick(8'd5, 16'h0F0F, 16'h0F0F);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start        = 1'b1;
        num_patterns = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Back-to-back: start in the cycle right after COMPARE, N=1.
        push(1'b1, 1, 1, 3, 6, 1);
        kick(8'd1, 16'h00AA, 16'h00AA);
        chk("b2b_done_cleared", 32'(done), 32'd0);
        wait_idle();

        // Full sweep: N=0 gives 256 increments and a wrapped counter.
        push(1'b1, 0, 256, 258, 261, 0);
        kick(8'd0, 16'hA5A5, 16'hA5A5);
        wait_idle();

        // Asynchronous reset in the middle of RUN, between clock edges.
        kick(8'd10, 16'h1111, 16'h1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_strobes", {gen_inc, gen_clear, misr_clear, misr_en, test_mode, busy, done, pass}, 32'd0);
        chk("midrun_rst_prun", 32'(patterns_run), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_busy", 32'(busy), 32'd0);
        chk("after_rst_done", 32'(done), 32'd0);

        @(posedge clk); #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
